// File: rtl/aes_128_pkg.sv
// Shared AES-128 constants, key-memory FSM encodings and the GF(2^8) doubling
// helper that the encipher MixColumns also uses.
package aes_128_pkg;

  localparam logic [3:0] AES128_ROUNDS = 4'ha;

  typedef enum logic [1:0] {
    KM_IDLE     = 2'd0,
    KM_INIT     = 2'd1,
    KM_GENERATE = 2'd2
  } km_state_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gm2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
  endfunction

endpackage

// File: rtl/aes_128_key_mem.sv
// AES-128 key expansion and round-key table: one round key per cycle after init,
// then combinational lookup by round index. SubWord comes from an external S-box unit.
module aes_128_key_mem
  import aes_128_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic [127:0] key,
  input  logic         init,
  input  logic [3:0]   round,
  output logic [127:0] round_key,
  output logic         ready,
  output logic [31:0]  sbox,
  input  logic [31:0]  new_sbox
);

  logic [127:0] r_slot [0:10];
  logic [127:0] r_prev_key;
  logic [7:0]   r_rcon;
  logic [3:0]   r_round_ctr;
  logic         r_ready;
  km_state_e    r_state;

  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [31:0]  w_t, w_k0, w_k1, w_k2, w_k3;
  logic [127:0] w_next_key;
  logic [127:0] w_slot_din;
  logic [10:0]  w_slot_we;

  assign w_w0 = r_prev_key[127:96];
  assign w_w1 = r_prev_key[95:64];
  assign w_w2 = r_prev_key[63:32];
  assign w_w3 = r_prev_key[31:0];

  // Rotating after substitution gives the same word as RotWord then SubWord.
  assign w_t  = {new_sbox[23:0], new_sbox[31:24]} ^ {r_rcon, 24'h0};
  assign w_k0 = w_w0 ^ w_t;
  assign w_k1 = w_w1 ^ w_k0;
  assign w_k2 = w_w2 ^ w_k1;
  assign w_k3 = w_w3 ^ w_k2;
  assign w_next_key = {w_k0, w_k1, w_k2, w_k3};

  assign sbox  = (r_state == KM_GENERATE) ? w_w3 : 32'h0;
  assign ready = r_ready;

  assign w_slot_din = (r_state == KM_INIT) ? key : w_next_key;

  generate
    for (genvar gi = 0; gi <= 10; gi++) begin : g_slot_we
      if (gi == 0) begin : g_first
        assign w_slot_we[gi] = (r_state == KM_INIT);
      end else begin : g_rest
        assign w_slot_we[gi] = (r_state == KM_GENERATE) && (r_round_ctr == 4'(gi));
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= 10; i++) r_slot[i] <= '0;
    end else begin
      for (int i = 0; i <= 10; i++) begin
        if (w_slot_we[i]) r_slot[i] <= w_slot_din;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= KM_IDLE;
      r_ready     <= 1'b1;
      r_prev_key  <= '0;
      r_rcon      <= '0;
      r_round_ctr <= '0;
    end else begin
      case (r_state)
        KM_IDLE: begin
          if (init && r_ready) begin
            r_ready <= 1'b0;
            r_state <= KM_INIT;
          end
        end
        KM_INIT: begin
          r_prev_key  <= key;
          r_rcon      <= 8'h01;
          r_round_ctr <= 4'd1;
          r_state     <= KM_GENERATE;
        end
        KM_GENERATE: begin
          r_prev_key  <= w_next_key;
          r_rcon      <= gm2(r_rcon);
          r_round_ctr <= r_round_ctr + 4'd1;
          if (r_round_ctr == AES128_ROUNDS) begin
            r_ready <= 1'b1;
            r_state <= KM_IDLE;
          end
        end
        default: begin
          r_state <= KM_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Indices 11..15 fall through to zero.
  always_comb begin
    round_key = '0;
    for (int i = 0; i <= 10; i++) begin
      if (round == 4'(i)) round_key = r_slot[i];
    end
  end

endmodule

// File: tb/tb_aes_128_key_mem.sv
// Self-checking bench for aes_128_key_mem: behavioural S-box, reference key
// expansion feeding a scoreboard queue, plus known-answer and timing checks.
module tb_aes_128_key_mem;

  logic         clk;
  logic         reset_n;
  logic [127:0] key;
  logic         init;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         ready;
  logic [31:0]  sbox;
  logic [31:0]  new_sbox;

  int n_total = 0;
  int n_bad   = 0;
  logic [127:0] sb_q [$];

  localparam logic [127:0] KA = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KB = 128'h000102030405060708090a0b0c0d0e0f;

  aes_128_key_mem dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key       (key),
    .init      (init),
    .round     (round),
    .round_key (round_key),
    .ready     (ready),
    .sbox      (sbox),
    .new_sbox  (new_sbox)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h0;
    logic hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sub_byte(input logic [7:0] x);
    logic [7:0] p = x;
    logic [7:0] r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
  endfunction

  assign new_sbox = sub_word(sbox);

  function automatic logic [7:0] rcon_of(input int i);
    case (i)
      1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
      5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
      9: return 8'h1b; 10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_model(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon_of(i/4), 24'h0};
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++) sb_q.push_back({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
  endtask

  task automatic read_table(input string pfx);
    logic [127:0] exp;
    for (int r = 0; r <= 10; r++) begin
      round = 4'(r);
      #1;
      if (sb_q.size() == 0) begin
        check($sformatf("%s_q_empty_r%0d", pfx, r), round_key, 128'hx);
      end else begin
        exp = sb_q.pop_front();
        $display("rd %s round=%0d key=%h", pfx, r, round_key);
        check($sformatf("%s_r%0d", pfx, r), round_key, exp);
      end
    end
  endtask

  // Counts consecutive negedges on which ready equals lvl (bounded).
  task automatic count_level(input logic lvl, output int n);
    n = 0;
    while (ready === lvl && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic start_init(input logic [127:0] k);
    @(negedge clk);
    key  = k;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b0;
    init    = 1'b0;
    key     = '0;
    round   = '0;
    repeat (2) @(negedge clk);

    check("rst_ready", 128'(ready), 128'd1);
    check("rst_sbox", 128'(sbox), 128'd0);
    for (int r = 0; r <= 10; r++) sb_q.push_back('0);
    read_table("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // Key A from the FIPS-197 appendix
    start_init(KA);
    push_model(KA);
    count_level(1'b0, n);
    check("lat_a", 128'(n), 128'd11);
    read_table("a");
    round = 4'd0;  #1; check("kat_a_r0", round_key, KA);
    round = 4'd1;  #1; check("kat_a_r1", round_key, 128'ha0fafe1788542cb123a339392a6c7605);
    round = 4'd10; #1; check("kat_a_r10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    start_init(KB);
    push_model(KB);
    count_level(1'b0, n);
    check("lat_b", 128'(n), 128'd11);
    read_table("b");
    round = 4'd10; #1; check("kat_b_r10", round_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // init with key B at E5 of a key A expansion must be ignored
    start_init(KA);
    push_model(KA);
    repeat (4) @(negedge clk);
    key  = KB;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    count_level(1'b0, n);
    check("lat_ign", 128'(n), 128'd6);
    read_table("ign");
    @(negedge clk);
    check("ign_idle", 128'(ready), 128'd1);

    // Async reset at E6 of an expansion
    start_init(KB);
    round = 4'd0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_ready", 128'(ready), 128'd1);
    check("mid_rst_r0", round_key, 128'd0);
    check("mid_rst_sbox", 128'(sbox), 128'd0);
    round = 4'd10; #1; check("mid_rst_r10", round_key, 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    start_init(KA);
    push_model(KA);
    count_level(1'b0, n);
    check("lat_rerun", 128'(n), 128'd11);
    read_table("rerun");

    round = 4'd11; #1; check("r11_zero", round_key, 128'd0);
    round = 4'd15; #1; check("r15_zero", round_key, 128'd0);

    // init held high: back-to-back expansions
    @(negedge clk);
    key  = KB;
    init = 1'b1;
    @(negedge clk);
    count_level(1'b0, n);
    check("b2b_low1", 128'(n), 128'd11);
    count_level(1'b1, n);
    check("b2b_high", 128'(n), 128'd1);
    init = 1'b0;
    count_level(1'b0, n);
    check("b2b_low2", 128'(n), 128'd11);
    push_model(KB);
    read_table("b2b");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_128_key_mem.md
# aes_128_key_mem

AES-128 key expansion and round-key store. It is the upstream neighbour of the encipher datapath. On `init` it expands the 128-bit cipher key into 11 round keys (KeyExpansion(), FIPS-197 §5.2), generating one key per cycle. It then serves `round_key` combinationally for whichever `round` index the encipher block presents. SubWord() is not done here: the block drives a 32-bit word to an external S-box word unit and reads back the substituted word, in the same way the encipher block does.

## Interface
- Parameters: none. Key size is fixed at 128 bits, 10 rounds.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `key`  in  128  cipher key; sampled only in INIT state.
- `init`  in  1  start expansion; honoured only when `ready`=1.
- `round`  in  4  round-key index 0..10, from the encipher block's round counter.
- `round_key`  out  128  stored key for `round`.
- `ready`  out  1  1 = idle, key table valid; 0 = expansion in progress.
- `sbox`  out  32  word sent to external S-box unit.
- `new_sbox`  in  32  SubWord(`sbox`), combinational return.

## Operation
- Storage: 11 × 128-bit key slots, plus these registers:
  - `prev_key` (128)
  - `rcon` (8)
  - `round_ctr` (4)
  - FSM state
  - `ready`
- FSM states: IDLE, INIT, GENERATE.
- IDLE:
  - With `init`=1: clear `ready` and go to INIT.
  - With `init`=0: stay in IDLE.
- INIT:
  - slot0 ← `key`; `prev_key` ← `key`.
  - `rcon` ← 8'h01; `round_ctr` ← 1.
  - Go to GENERATE.
- GENERATE:
  - Split `prev_key` into words {w0,w1,w2,w3}, w0 = MSW.
  - `sbox` = w3; s = `new_sbox`.
  - t = {s[23:16], s[15:8], s[7:0], s[31:24]} ^ {`rcon`, 24'h0}. Rotation is applied after substitution, which is equivalent to RotWord before SubWord.
  - k0 = w0^t, k1 = w1^k0, k2 = w2^k1, k3 = w3^k2.
  - slot[`round_ctr`] ← {k0,k1,k2,k3}; `prev_key` ← same value.
  - `rcon` ← xtime(`rcon`), where xtime(x) = {x[6:0],0} ^ (8'h1b & {8{x[7]}}).
  - `round_ctr` ← +1.
  - When `round_ctr`==10 is written: set `ready` ← 1 and go to IDLE.
- `sbox` = 32'h0 outside GENERATE.
- `round_key` = slot[`round`], read combinationally.
  - `round` 11..15 returns 128'h0.
- `init` while `ready`=0: ignored. No restart and no queuing.
- Reading `round_key` while `ready`=0 returns the current slot contents: old, new or zero. The consumer must not start encipher until `ready`=1.
- `key` changing after INIT has no effect until the next `init`.

## Timing
- Reset values:
  - `ready`=1
  - all slots 0, so `round_key`=0
  - `prev_key`=0, `rcon`=0, `round_ctr`=0
  - state IDLE, `sbox`=0
- Edge E0 samples `init`=1 with `ready`=1. `ready` reads 0 after E0.
- E1: slot0 written.
- E2..E11: slots 1..10 written, one per edge.
- `ready` reads 1 after E11. Total latency is 11 cycles from the `init` sample, with `ready` low for exactly 11 cycles.
- `init` held high continuously starts a new expansion on the first edge where `ready`=1 again, i.e. E11+1.
- `rcon` sequence over slots 1..10: 01,02,04,08,10,20,40,80,1b,36.
- `round_key` is combinational from the `round` input. The encipher block may change `round` every cycle with zero-cycle lookup.
- Reset asserted mid-expansion:
  - Clears immediately and asynchronously to the reset values above.
  - Partially written slots are lost.
  - `ready`=1 on the same cycle reset is asserted.
- External S-box path is combinational: `sbox` → `new_sbox` must settle within one cycle.

## Structure
- Shared package `aes_128_pkg` holds:
  - AES128_ROUNDS = 4'ha
  - key-mem FSM state encodings (2 bits)
  - the xtime/gm2 function, so it is shared with the encipher MixColumns.
- No internal sub-module.
- The S-box word unit is instantiated at top level. It is time-shared with the encipher block and muxed by `ready`.
- Estimated size ~150–200 lines of RTL.

## Test plan
- Reset → `ready`=1, `round_key`=0 for `round`=0..10, `sbox`=0.
- `key`=2b7e151628aed2a6abf7158809cf4f3c, pulse `init` → `ready` low exactly 11 cycles. Then:
  - `round`=0 → 2b7e151628aed2a6abf7158809cf4f3c
  - `round`=1 → a0fafe1788542cb123a339392a6c7605
  - `round`=10 → d014f9a8c9ee2589e13f0cc8b6630ca6
- `key`=000102030405060708090a0b0c0d0e0f → `round`=10 gives 13111d7fe3944a17f307a78b4d2b30c5.
- While expanding key A, pulse `init` with key B at E5 → ignored; table completes with key A values.
- Deassert `reset_n` at E6 of an expansion → `ready`=1 and `round_key`=0 immediately. Then re-`init` with key A → correct table after 11 cycles.
- `round`=11 and `round`=15 after valid expansion → `round_key`=0. `init` held high → back-to-back expansions, each showing `ready` low for 11 cycles and high for 1 cycle.
